sim_jtag_tap: RTL and testbench
===============================

# sim_jtag_tap

Simulation-side JTAG test access port responder, the target end of the host-driven JTAG bit-bang stimulus. It oversamples `jtag_TCK`, `jtag_TMS`, `jtag_TDI` and `jtag_TRSTn` in the system clock domain and runs the IEEE 1149.1 16-state TAP controller. It implements IR, BYPASS, IDCODE and one user data register with a parallel capture/update interface. It drives `jtag_TDO_data`/`jtag_TDO_driven` back to the stimulus, and is used in benches that need a JTAG target without a real debug module.

## Interface
- `IR_WIDTH`, 5, instruction register width.
- `IDCODE`, 32'h0000_0001, IDCODE value; bit 0 must be 1.
- `IDCODE_INSTR`, 5'h01, selects IDCODE.
- `USER_INSTR`, 5'h11, selects the user DR.
- `DR_WIDTH`, 41, user DR width.
- `SYNC_STAGES`, 2, synchronizer depth for JTAG inputs (≥2).
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `jtag_TCK`, `jtag_TMS`, `jtag_TDI`, `jtag_TRSTn` in 1 each: JTAG pins; these are asynchronous to `clock`.
- `jtag_TDO_data` out 1: serial output.
- `jtag_TDO_driven` out 1: high only while shifting.
- `dr_capture_data` in DR_WIDTH: parallel value loaded at Capture-DR under USER_INSTR.
- `dr_update_valid` out 1: one-cycle pulse at Update-DR under USER_INSTR.
- `dr_update_data` out DR_WIDTH: shifted value; held until the next update.
- `ir_value` out IR_WIDTH: current IR.
- `tap_state` out 4: current TAP state (debug).

## Operation
- Each JTAG input passes through a SYNC_STAGES flop chain. `tck_q` is the last stage and `tck_p` is its previous value.
  - Rise event: `tck_q & ~tck_p`.
  - Fall event: `~tck_q & tck_p`.
  - TMS and TDI are sampled from their synchronized versions in the same cycle.
- Rise event:
  - The TAP state advances on TMS per the standard 16-state graph.
  - Actions are keyed on the state before the transition:
    - Capture-IR: IR shift reg ← {0…,2'b01}.
    - Shift-IR: shift right, TDI into MSB.
    - Capture-DR: selected DR loads; IDCODE ← IDCODE, BYPASS ← 0, USER ← `dr_capture_data`.
    - Shift-DR: selected DR shifts right, TDI into MSB.
- Fall event:
  - `jtag_TDO_data` ← LSB of the active shift register (IR shift reg in Shift-IR, selected DR in Shift-DR, else 0).
  - `jtag_TDO_driven` ← (state is Shift-IR or Shift-DR).
  - In Update-IR: IR ← IR shift reg.
  - In Update-DR with IR==USER_INSTR: `dr_update_data` ← USER shift reg and `dr_update_valid`=1 for exactly that cycle.
- DR select:
  - IR==IDCODE_INSTR selects the 32-bit IDCODE register.
  - IR==USER_INSTR selects the USER register.
  - Any other IR, including all-ones, selects the 1-bit BYPASS register.
- Test-Logic-Reset state: IR ← IDCODE_INSTR, whenever entered or held.
- Synchronized TRSTn low:
  - Same effect as `reset` on the TAP state, IR and TDO outputs.
  - `dr_update_data` holds its value.
  - TRSTn wins over a simultaneous TCK event; no update pulse is issued.
- Reset values:
  - `tap_state`=Test-Logic-Reset (4'hF).
  - `ir_value`=IDCODE_INSTR.
  - `jtag_TDO_data`=0, `jtag_TDO_driven`=0.
  - `dr_update_valid`=0, `dr_update_data`=0.
  - Shift registers = 0.
  - Synchronizer flops reset to TCK=0, TMS=1, TRSTn=1. No spurious edge is allowed after reset.
- Reset mid-scan aborts the scan with no update pulse.

## Timing
- Latency from a pin change to the action: SYNC_STAGES+1 `clock` cycles. All outputs are registered.
- TCK high and low phases must each last ≥ SYNC_STAGES+2 clocks. Shorter pulses are undefined.
- TMS and TDI must be stable for ≥ SYNC_STAGES+1 clocks before a TCK rise.
- The default stimulus pacing (about 51-clock half period) is well within limits.
- At most one TAP transition occurs per rise event.
- `dr_update_valid` lasts exactly one cycle per Update-DR visit. Back-to-back scans produce separate pulses.

## Structure
- Package `sim_jtag_tap_pkg` holds:
  - the 4-bit `tap_state_e` enum with standard 1149.1 encodings (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D);
  - the next-state function.
- Sub-module `sim_jtag_sync`, instantiated per input, contains the SYNC_STAGES synchronizer plus the previous-value flop and outputs the rise/fall strobes (used for TCK).

## Test plan
- Reset, then 5 TCK cycles with TMS=1 → `tap_state`=F throughout, `jtag_TDO_driven`=0, `ir_value`=5'h01.
- From reset, TMS 0,1,0,0, then 32 Shift-DR cycles → TDO bits LSB-first equal 32'h0000_0001; `jtag_TDO_driven`=1 only during the 32 shift cycles.
- Shift IR 5'h11 → captured bits out are 1,0,0,0,0. Then shift a 41-bit DR 41'h0AB_CDEF_0123 with `dr_capture_data`=41'h155_5555_5555 → TDO yields 41'h155_5555_5555 and a single `dr_update_valid` pulse with `dr_update_data`=41'h0AB_CDEF_0123.
- IR=5'h1F (BYPASS), shift 1,1,0,1 → TDO emits 0,1,1,0, i.e. a one-bit delay with leading 0.
- TRSTn low for 10 clocks mid Shift-DR under USER → `tap_state`=F within SYNC_STAGES+1 clocks, `jtag_TDO_driven`=0, `ir_value`=5'h01, no `dr_update_valid` pulse, and `dr_update_data` unchanged.
- Minimum-width TCK (SYNC_STAGES+2 clocks per phase) through the full IDCODE scan → same result as the nominal-speed scan.

Source files
------------

// File: rtl/sim_jtag_tap_pkg.sv
// ----------------------------------------------------------------------------
// sim_jtag_tap_pkg
// Shared types for the simulation JTAG TAP responder:
//   tap_state_e     - IEEE 1149.1 TAP states with their standard encodings
//   tap_next_state  - 16-state TAP transition function, advanced on TMS
// ----------------------------------------------------------------------------
package sim_jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_e;

    function automatic tap_state_e tap_next_state(input tap_state_e cur, input logic tms);
        tap_state_e nxt;
        case (cur)
            TAP_TLR:      nxt = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   nxt = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   nxt = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   nxt = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            default:      nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sim_jtag_sync.sv
// ----------------------------------------------------------------------------
// sim_jtag_sync
// Brings one asynchronous JTAG pin into the clock domain through a STAGES-deep
// flop chain, keeps the previous synchronized value and derives edge strobes.
//   clock, reset   - system clock, synchronous active-high reset
//   i_async        - raw pin
//   o_q            - synchronized level (last chain stage)
//   o_rise/o_fall  - one-cycle strobes on synchronized rising/falling edges
// RST_VAL is loaded into every stage and the previous-value flop so that no
// edge can be reported right after reset.
// ----------------------------------------------------------------------------
module sim_jtag_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise =  r_chain[STAGES-1] & ~r_prev;
    assign o_fall = ~r_chain[STAGES-1] &  r_prev;

endmodule

// File: rtl/sim_jtag_tap.sv
// ----------------------------------------------------------------------------
// sim_jtag_tap
// Simulation-side JTAG TAP target. Oversamples the JTAG pins in the clock
// domain and runs the 1149.1 TAP controller with IR, BYPASS, IDCODE and one
// user DR that has a parallel capture/update interface.
//   clock, reset              - system clock, synchronous active-high reset
//   jtag_TCK/TMS/TDI/TRSTn    - asynchronous JTAG pins
//   jtag_TDO_data/_driven     - serial output and its drive-enable
//   dr_capture_data           - loaded into the user DR at Capture-DR
//   dr_update_valid/_data     - one-cycle pulse and held value at Update-DR
//   ir_value, tap_state       - current IR and TAP state (debug)
//
// state    | meaning
// ---------+----------------------------------------------
// TLR  (F) | test-logic-reset, IR forced to IDCODE_INSTR
// RTI  (C) | run-test/idle
// SelDR(7) | DR column entry      SelIR(4) | IR column entry
// CapDR(6) | load selected DR     CapIR(E) | load 2'b01 into IR shift reg
// ShDR (2) | shift selected DR    ShIR (A) | shift IR shift reg
// Ex1/Pause/Ex2 (1,3,0 / 9,B,8)   | scan pause/exit path
// UpdDR(5) | user DR update pulse UpdIR(D) | IR <- IR shift reg
// ----------------------------------------------------------------------------
module sim_jtag_tap
    import sim_jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE       = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 5'h01,
    parameter logic [IR_WIDTH-1:0] USER_INSTR   = 5'h11,
    parameter int                  DR_WIDTH     = 41,
    parameter int                  SYNC_STAGES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic                dr_update_valid,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    logic w_tck_rise, w_tck_fall, w_tms, w_tdi, w_trst_n;
    logic w_tck_unused_q;
    logic w_tms_unused_rise, w_tms_unused_fall;
    logic w_tdi_unused_rise, w_tdi_unused_fall;
    logic w_trst_unused_rise, w_trst_unused_fall;

    sim_jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
        .clock(clock), .reset(reset), .i_async(jtag_TCK),
        .o_q(w_tck_unused_q), .o_rise(w_tck_rise), .o_fall(w_tck_fall)
    );
    sim_jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tms (
        .clock(clock), .reset(reset), .i_async(jtag_TMS),
        .o_q(w_tms), .o_rise(w_tms_unused_rise), .o_fall(w_tms_unused_fall)
    );
    sim_jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
        .clock(clock), .reset(reset), .i_async(jtag_TDI),
        .o_q(w_tdi), .o_rise(w_tdi_unused_rise), .o_fall(w_tdi_unused_fall)
    );
    sim_jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_trst (
        .clock(clock), .reset(reset), .i_async(jtag_TRSTn),
        .o_q(w_trst_n), .o_rise(w_trst_unused_rise), .o_fall(w_trst_unused_fall)
    );

    tap_state_e          r_state;
    tap_state_e          w_state_nxt;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [31:0]         r_dr_id;
    logic                r_dr_byp;
    logic [DR_WIDTH-1:0] r_dr_user;
    logic                r_tdo;
    logic                r_tdo_en;
    logic                r_upd_valid;
    logic [DR_WIDTH-1:0] r_upd_data;

    logic w_sel_id, w_sel_user;
    logic w_dr_lsb, w_tdo_nxt, w_tdo_en_nxt;

    // TAP state register; TRSTn overrides any TCK edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_trst_n) begin
            w_state_nxt = TAP_TLR;
        end else if (w_tck_rise) begin
            w_state_nxt = tap_next_state(r_state, w_tms);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Anything other than IDCODE or USER falls through to BYPASS.
    always_comb begin
        w_sel_id     = (r_ir == IDCODE_INSTR);
        w_sel_user   = (r_ir == USER_INSTR);
        w_dr_lsb     = r_dr_byp;
        w_tdo_nxt    = 1'b0;
        w_tdo_en_nxt = 1'b0;
        if (w_sel_id) begin
            w_dr_lsb = r_dr_id[0];
        end else if (w_sel_user) begin
            w_dr_lsb = r_dr_user[0];
        end
        if (r_state == TAP_SH_IR) begin
            w_tdo_nxt    = r_ir_shift[0];
            w_tdo_en_nxt = 1'b1;
        end else if (r_state == TAP_SH_DR) begin
            w_tdo_nxt    = w_dr_lsb;
            w_tdo_en_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir        <= IDCODE_INSTR;
            r_ir_shift  <= '0;
            r_dr_id     <= '0;
            r_dr_byp    <= 1'b0;
            r_dr_user   <= '0;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_data  <= '0;
        end else if (!w_trst_n) begin
            // Scan aborted: no update pulse, last delivered update data kept.
            r_ir        <= IDCODE_INSTR;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
            r_upd_valid <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;

            if (r_state == TAP_TLR) begin
                r_ir <= IDCODE_INSTR;
            end

            // Rise actions are keyed on the state before the transition.
            if (w_tck_rise) begin
                case (r_state)
                    TAP_CAP_IR: r_ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
                    TAP_SH_IR:  r_ir_shift <= {w_tdi, r_ir_shift[IR_WIDTH-1:1]};
                    TAP_CAP_DR: begin
                        if (w_sel_id) begin
                            r_dr_id <= IDCODE;
                        end else if (w_sel_user) begin
                            r_dr_user <= dr_capture_data;
                        end else begin
                            r_dr_byp <= 1'b0;
                        end
                    end
                    TAP_SH_DR: begin
                        if (w_sel_id) begin
                            r_dr_id <= {w_tdi, r_dr_id[31:1]};
                        end else if (w_sel_user) begin
                            r_dr_user <= {w_tdi, r_dr_user[DR_WIDTH-1:1]};
                        end else begin
                            r_dr_byp <= w_tdi;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_tck_fall) begin
                r_tdo    <= w_tdo_nxt;
                r_tdo_en <= w_tdo_en_nxt;
                if (r_state == TAP_UPD_IR) begin
                    r_ir <= r_ir_shift;
                end
                if (r_state == TAP_UPD_DR && w_sel_user) begin
                    r_upd_data  <= r_dr_user;
                    r_upd_valid <= 1'b1;
                end
            end
        end
    end

    assign jtag_TDO_data   = r_tdo;
    assign jtag_TDO_driven = r_tdo_en;
    assign dr_update_valid = r_upd_valid;
    assign dr_update_data  = r_upd_data;
    assign ir_value        = r_ir;
    assign tap_state       = r_state;

endmodule

// File: tb/tb_sim_jtag_tap.sv
// ----------------------------------------------------------------------------
// tb_sim_jtag_tap
// Directed bench for sim_jtag_tap: bit-bangs JTAG scans from the clock domain
// and compares TDO streams, TAP state, IR and update interface against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_sim_jtag_tap;

    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
    logic [40:0] dr_capture_data;
    logic        dr_update_valid;
    logic [40:0] dr_update_data;
    logic [4:0]  ir_value;
    logic [3:0]  tap_state;

    int   n_total = 0;
    int   n_bad   = 0;
    int   half    = 51;
    int   pulse_cnt = 0;
    int   hi_cnt    = 0;
    logic valid_d   = 1'b0;

    sim_jtag_tap dut (
        .clock           (clock),
        .reset           (reset),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .dr_capture_data (dr_capture_data),
        .dr_update_valid (dr_update_valid),
        .dr_update_data  (dr_update_data),
        .ir_value        (ir_value),
        .tap_state       (tap_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        valid_d <= dr_update_valid;
        if (dr_update_valid) hi_cnt <= hi_cnt + 1;
        if (dr_update_valid && !valid_d) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One TCK period; tdo/drv are sampled just before the rising edge.
    task automatic jtag_clk(input logic tms, input logic tdi, output logic tdo, output logic drv);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (half) @(negedge clock);
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
        jtag_TCK = 1'b1;
        repeat (half) @(negedge clock);
        jtag_TCK = 1'b0;
    endtask

    // RTI -> Shift-IR, shift v LSB-first, Update-IR, back to RTI.
    task automatic scan_ir(input logic [4:0] v, output logic [4:0] cap);
        logic tdo, drv;
        cap = '0;
        jtag_clk(1'b1, 1'b0, tdo, drv);
        jtag_clk(1'b1, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        chk("st_shir", {60'd0, tap_state}, 64'hA);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, v[i], tdo, drv);
            cap[i] = tdo;
        end
        jtag_clk(1'b1, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        chk("st_rti_ir", {60'd0, tap_state}, 64'hC);
    endtask

    // RTI -> Shift-DR, n-bit scan, Update-DR, back to RTI.
    // ndrv counts driven samples in the shift window, nout those outside it.
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output int ndrv, output int nout);
        logic tdo, drv;
        dout = '0;
        ndrv = 0;
        nout = 0;
        jtag_clk(1'b1, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        nout += int'(drv);
        chk("st_shdr", {60'd0, tap_state}, 64'h2);
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], tdo, drv);
            dout[i] = tdo;
            ndrv += int'(drv);
        end
        jtag_clk(1'b1, 1'b0, tdo, drv);
        nout += int'(drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        chk("st_rti_dr", {60'd0, tap_state}, 64'hC);
    endtask

    initial begin
        logic        tdo, drv;
        logic [63:0] dout;
        logic [4:0]  cap;
        int          ndrv, nout;

        jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
        dr_capture_data = '0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_state", {60'd0, tap_state}, 64'hF);
        chk("rst_ir", {59'd0, ir_value}, 64'h01);
        chk("rst_tdo", {63'd0, jtag_TDO_data}, 64'h0);
        chk("rst_drv", {63'd0, jtag_TDO_driven}, 64'h0);
        chk("rst_valid", {63'd0, dr_update_valid}, 64'h0);
        chk("rst_upd", {23'd0, dr_update_data}, 64'h0);

        for (int i = 0; i < 5; i++) begin
            jtag_clk(1'b1, 1'b0, tdo, drv);
            chk("tlr_state", {60'd0, tap_state}, 64'hF);
            chk("tlr_drv", {63'd0, jtag_TDO_driven}, 64'h0);
        end
        chk("tlr_ir", {59'd0, ir_value}, 64'h01);

        jtag_clk(1'b0, 1'b0, tdo, drv);
        chk("st_rti", {60'd0, tap_state}, 64'hC);

        // IDCODE scan at nominal speed
        scan_dr(32, 64'd0, dout, ndrv, nout);
        chk("idcode", dout, 64'h0000_0001);
        chk("idcode_drv", ndrv, 32);
        chk("idcode_undrv", nout, 0);
        chk("idcode_nopulse", pulse_cnt, 0);

        // user DR scan
        scan_ir(5'h11, cap);
        chk("ir_cap", {59'd0, cap}, 64'h01);
        chk("ir_user", {59'd0, ir_value}, 64'h11);
        dr_capture_data = 41'h155_5555_5555;
        scan_dr(41, 64'h0AB_CDEF_0123, dout, ndrv, nout);
        chk("user_tdo", dout, 64'h155_5555_5555);
        chk("user_drv", ndrv, 41);
        chk("user_pulse", pulse_cnt, 1);
        chk("user_hi", hi_cnt, 1);
        chk("user_upd", {23'd0, dr_update_data}, 64'h0AB_CDEF_0123);

        // back-to-back user scans give separate pulses
        dr_capture_data = 41'h0FF_0000_00FF;
        scan_dr(41, 64'h100_0000_0001, dout, ndrv, nout);
        chk("b2b_upd1", {23'd0, dr_update_data}, 64'h100_0000_0001);
        scan_dr(41, 64'h000_1234_5678, dout, ndrv, nout);
        chk("b2b_tdo2", dout, 64'h0FF_0000_00FF);
        chk("b2b_pulse", pulse_cnt, 3);
        chk("b2b_hi", hi_cnt, 3);
        chk("b2b_upd2", {23'd0, dr_update_data}, 64'h000_1234_5678);

        // BYPASS via all-ones IR
        scan_ir(5'h1F, cap);
        chk("byp_ircap", {59'd0, cap}, 64'h01);
        chk("byp_ir", {59'd0, ir_value}, 64'h1F);
        scan_dr(4, 64'hB, dout, ndrv, nout);
        chk("byp_tdo", dout, 64'h6);
        chk("byp_drv", ndrv, 4);
        chk("byp_nopulse", pulse_cnt, 3);

        // Test-Logic-Reset reloads IDCODE_INSTR
        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, tdo, drv);
        chk("tlr2_state", {60'd0, tap_state}, 64'hF);
        chk("tlr2_ir", {59'd0, ir_value}, 64'h01);
        jtag_clk(1'b0, 1'b0, tdo, drv);

        // TRSTn mid Shift-DR under USER, coincident with a TCK fall
        scan_ir(5'h11, cap);
        jtag_clk(1'b1, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        ndrv = 0;
        for (int i = 0; i < 10; i++) begin
            jtag_clk(1'b0, i[0], tdo, drv);
            ndrv += int'(drv);
        end
        chk("trst_pre_drv", ndrv, 10);
        chk("trst_pre_st", {60'd0, tap_state}, 64'h2);
        jtag_TRSTn = 1'b0;
        repeat (SYNC + 1) @(negedge clock);
        chk("trst_state", {60'd0, tap_state}, 64'hF);
        chk("trst_drv", {63'd0, jtag_TDO_driven}, 64'h0);
        chk("trst_tdo", {63'd0, jtag_TDO_data}, 64'h0);
        chk("trst_ir", {59'd0, ir_value}, 64'h01);
        repeat (10 - (SYNC + 1)) @(negedge clock);
        jtag_TRSTn = 1'b1;
        repeat (5) @(negedge clock);
        chk("trst_nopulse", pulse_cnt, 3);
        chk("trst_upd_hold", {23'd0, dr_update_data}, 64'h000_1234_5678);
        chk("trst_rel_state", {60'd0, tap_state}, 64'hF);
        jtag_clk(1'b0, 1'b0, tdo, drv);
        chk("trst_rti", {60'd0, tap_state}, 64'hC);

        // IDCODE scan at minimum TCK phase width
        half = SYNC + 2;
        scan_dr(32, 64'd0, dout, ndrv, nout);
        chk("fast_idcode", dout, 64'h0000_0001);
        chk("fast_drv", ndrv, 32);
        chk("fast_undrv", nout, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
